// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like memory port between instruction fetch and data access
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);
  localparam int RUN_W = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t            state_q, state_d;
  logic              owner_data_q, owner_data_d;
  logic              drop_q, drop_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              starve, grant_inst, grant_data;
  // Arbitration: data wins unless fetch has waited through STARVE_LIMIT data grants
  always_comb begin
    starve     = STARVE_LIMIT != 0 && run_q == RUN_MAX && inst_req && !flush;
    grant_inst = state_q == IDLE && (starve || (!data_req && inst_req && !flush));
    grant_data = state_q == IDLE && data_req && !starve;
  end
  // Next-state: transaction sequencing, request capture, flush drop flag, starvation count
  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    drop_d       = drop_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if (grant_inst || grant_data) begin
      state_d      = ADDR;
      owner_data_d = grant_data;
      wr_d         = grant_data ? data_wr : inst_wr;
      size_d       = grant_data ? data_size : inst_size;
      addr_d       = grant_data ? data_addr : inst_addr;
      wdata_d      = grant_data ? data_wdata : inst_wdata;
    end else if (state_q == ADDR && bus_addr_ok) begin
      state_d = DATA;
    end else if (state_q == DATA && bus_data_ok) begin
      state_d = IDLE;
    end
    if (state_q != IDLE && !owner_data_q && flush) drop_d = 1'b1;
    if (state_d == IDLE) drop_d = 1'b0;
    run_d = (!inst_req || grant_inst) ? '0 :
            (grant_data && run_q != RUN_MAX) ? run_q + RUN_W'(1) : run_q;
  end
  // State and captured-request registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      drop_q       <= 1'b0;
      run_q        <= '0;
      wr_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      drop_q       <= drop_d;
      run_q        <= run_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end
  // Outputs: grants are gated by reset so nothing is accepted while resetn is low
  always_comb begin
    inst_addr_ok = resetn && grant_inst;
    data_addr_ok = resetn && grant_data;
    inst_data_ok = state_q == DATA && !owner_data_q && bus_data_ok && !drop_q && !flush;
    data_data_ok = state_q == DATA && owner_data_q && bus_data_ok;
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
    bus_req      = state_q == ADDR;
    bus_wr       = wr_q;
    bus_size     = size_q;
    bus_addr     = addr_q;
    bus_wdata    = wdata_q;
  end
endmodule
